// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART receiver constants and FSM state encoding
package uart_defs;

    localparam int DEFAULT_BAUD_DIV = 434;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with count-based full/empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNTW'(DEPTH));
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a small byte FIFO with sticky error flags
module uart_rx_fifo
    import uart_defs::*;
#(
    parameter int RATE_FREQ_BAUD = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       data_av,
    output logic       frame_err,
    output logic       overrun,
    output logic       irq
);

    localparam int HALF = RATE_FREQ_BAUD / 2;
    localparam int CW   = $clog2(RATE_FREQ_BAUD);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(RATE_FREQ_BAUD - 1);

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_sample;
    logic          push;
    logic          set_fe;
    logic          set_ovr;
    logic          empty;
    logic          full;

    assign stop_sample = (state == ST_STOP) && (cnt == BIT_LAST);
    assign push        = stop_sample && rx_s;
    assign set_fe      = stop_sample && !rx_s;
    assign set_ovr     = push && full && !rd;

    assign data_av = !empty;
    assign irq     = data_av;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd),
        .din   (shreg),
        .dout  (data_out),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it cannot look like a fresh start bit.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (set_fe) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end

            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int RATE  = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_out;
    logic       data_av;
    logic       frame_err;
    logic       overrun;
    logic       irq;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];
    logic       exp_ovr = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .RATE_FREQ_BAUD (RATE),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd        (rd),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .data_av   (data_av),
        .frame_err (frame_err),
        .overrun   (overrun),
        .irq       (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk); #1 rx = 1'b0;
        repeat (RATE) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (RATE) @(posedge clk);
        end
        #1 rx = stop;
        repeat (RATE) @(posedge clk);
        #1;
    endtask

    task automatic send_good(input logic [7:0] d);
        if (sb.size() < DEPTH) sb.push_back(d);
        else exp_ovr = 1'b1;
        send_frame(d, 1'b1);
    endtask

    task automatic read_check(input string name);
        int n;
        logic [7:0] exp;
        n = 0;
        @(negedge clk);
        while (!data_av && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_av"}, 32'(data_av), 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        check({name, "_data"}, 32'(data_out), 32'(exp));
        check({name, "_irq"}, 32'(irq), 32'(data_av));
        @(posedge clk); #1 rd = 1'b1;
        @(posedge clk); #1 rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'hAA, 1'b1, 1'b0};
        vecs[3] = '{8'h81, 1'b0, 1'b1};
        vecs[4] = '{8'h5A, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_data_av", 32'(data_av), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        // Test 1: exact data_av latency for 0xA5, then a single rd pulse empties the FIFO
        sb.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                @(negedge clk);
                check("t1_av_before_stop", 32'(data_av), 32'h0);
                @(posedge clk);
                @(negedge clk);
                check("t1_av_after_stop", 32'(data_av), 32'h1);
                check("t1_data_early", 32'(data_out), 32'hA5);
            end
        join
        read_check("t1_read");
        @(negedge clk);
        check("t1_av_after_rd", 32'(data_av), 32'h0);

        // Test 2: short low glitch is rejected
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("t2_av", 32'(data_av), 32'h0);
        check("t2_frame_err", 32'(frame_err), 32'h0);
        check("t2_overrun", 32'(overrun), 32'h0);

        // Test 3: bad stop bit with the line held low, then recovery
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t3_frame_err", 32'(frame_err), 32'h1);
        check("t3_no_data", 32'(data_av), 32'h0);
        send_good(8'h11);
        read_check("t3_read_11");
        @(negedge clk);
        check("t3_empty", 32'(data_av), 32'h0);
        pulse_clr();
        @(negedge clk);
        check("t3_fe_cleared", 32'(frame_err), 32'h0);

        // Table-driven patterns, including a framing-error entry
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            #1 rx = 1'b1;
            if (vecs[v].stop) sb.push_back(vecs[v].data);
            repeat (40) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_fe));
            if (vecs[v].stop) read_check($sformatf("vec%0d_read", v));
            else check($sformatf("vec%0d_no_data", v), 32'(data_av), 32'h0);
            pulse_clr();
        end

        // Test 4: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t4_overrun", 32'(overrun), 32'(exp_ovr));
        for (int i = 0; i < 4; i++) read_check($sformatf("t4_read%0d", i));
        @(negedge clk);
        check("t4_empty", 32'(data_av), 32'h0);
        pulse_clr();
        @(negedge clk);
        check("t4_ovr_cleared", 32'(overrun), 32'h0);

        // Test 5: rd coincident with a push into a full FIFO
        for (int i = 1; i <= 4; i++) send_good(8'(i));
        void'(sb.pop_front());
        sb.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
        @(negedge clk);
        check("t5_overrun", 32'(overrun), 32'h0);
        for (int i = 0; i < 4; i++) read_check($sformatf("t5_read%0d", i));
        @(negedge clk);
        check("t5_empty", 32'(data_av), 32'h0);

        // Test 6: reset in the middle of data bit 4 with two bytes queued
        send_good(8'h5A);
        send_good(8'hC3);
        @(negedge clk);
        check("t6_queued", 32'(data_av), 32'h1);
        @(posedge clk); #1 rx = 1'b0;
        repeat (RATE) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = 8'h96 >> i;
            repeat (RATE) @(posedge clk);
        end
        #1 rx = 1'b1;
        repeat (RATE / 2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("t6_data_out", 32'(data_out), 32'h0);
        check("t6_data_av", 32'(data_av), 32'h0);
        check("t6_frame_err", 32'(frame_err), 32'h0);
        check("t6_overrun", 32'(overrun), 32'h0);
        check("t6_irq", 32'(irq), 32'h0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("t6_idle_after_reset", 32'(data_av), 32'h0);
        send_good(8'h7E);
        read_check("t6_read_7e");
        @(negedge clk);
        check("t6_empty", 32'(data_av), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
